// File: rtl/nibble_serial_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: nibble width and FSM encodings.
package nibble_serial_sub_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub4_slice.sv
// 4-bit combinational borrow-ripple subtract slice: s = x - y - bi, bo = borrow out.
module sub4_slice
    import nibble_serial_sub_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             bi,
    output logic [NIB_W-1:0] s,
    output logic             bo
);

    logic [NIB_W:0] br;

    assign br[0] = bi;

    for (genvar i = 0; i < NIB_W; i++) begin : g_bit
        assign s[i]    = x[i] ^ y[i] ^ br[i];
        assign br[i+1] = (~x[i] & y[i]) | (br[i] & ~(x[i] ^ y[i]));
    end

    assign bo = br[NIB_W];

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-word subtractor d = a - b - bin, computed one nibble per clock through a
// single 4-bit slice with the borrow carried in a flop between nibbles.
module nibble_serial_sub
    import nibble_serial_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(NNIB);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NNIB - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             brw;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic [NIB_W-1:0] nib_x;
    logic [NIB_W-1:0] nib_y;
    logic [NIB_W-1:0] nib_s;
    logic             nib_bo;
    logic [WIDTH-1:0] d_nxt;

    assign nib_x = op_a[int'(idx)*NIB_W +: NIB_W];
    assign nib_y = op_b[int'(idx)*NIB_W +: NIB_W];

    sub4_slice u_slice (
        .x  (nib_x),
        .y  (nib_y),
        .bi (brw),
        .s  (nib_s),
        .bo (nib_bo)
    );

    // zero must see the fully assembled word, including the nibble written this edge
    always_comb begin
        d_nxt = d;
        d_nxt[int'(idx)*NIB_W +: NIB_W] = nib_s;
    end

    // Operands are data only: loaded on an accepted start, never reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            op_a <= a;
            op_b <= b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            brw   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        idx   <= '0;
                        brw   <= bin;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    d   <= d_nxt;
                    brw <= nib_bo;
                    if (idx == IDX_LAST) begin
                        bout  <= nib_bo;
                        zero  <= (d_nxt == '0);
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
